// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: default data width, register IDs and instruction codes.
package y86_pkg;

    localparam int XLEN_DEF = 64;

    // Register ID meaning "no register"
    localparam logic [3:0] RNONE = 4'hF;

    // Architectural register IDs
    localparam logic [3:0] RAX = 4'd0;
    localparam logic [3:0] RCX = 4'd1;
    localparam logic [3:0] RDX = 4'd2;
    localparam logic [3:0] RBX = 4'd3;
    localparam logic [3:0] RSP = 4'd4;
    localparam logic [3:0] RBP = 4'd5;
    localparam logic [3:0] RSI = 4'd6;
    localparam logic [3:0] RDI = 4'd7;
    localparam logic [3:0] R8  = 4'd8;
    localparam logic [3:0] R9  = 4'd9;
    localparam logic [3:0] R10 = 4'd10;
    localparam logic [3:0] R11 = 4'd11;
    localparam logic [3:0] R12 = 4'd12;
    localparam logic [3:0] R13 = 4'd13;
    localparam logic [3:0] R14 = 4'd14;

    // Instruction codes used upstream to select dstE/dstM
    typedef enum logic [3:0] {
        I_HALT   = 4'h0,
        I_NOP    = 4'h1,
        I_RRMOVQ = 4'h2,
        I_IRMOVQ = 4'h3,
        I_RMMOVQ = 4'h4,
        I_MRMOVQ = 4'h5,
        I_OPQ    = 4'h6,
        I_JXX    = 4'h7,
        I_CALL   = 4'h8,
        I_RET    = 4'h9,
        I_PUSHQ  = 4'hA,
        I_POPQ   = 4'hB
    } icode_e;

    // True when a register ID names a real architectural register
    function automatic logic id_in_range(input logic [3:0] id,
                                         input logic [3:0] none_id,
                                         input int         nregs);
        return (id != none_id) && (int'(id) < nregs);
    endfunction

endpackage

// File: rtl/y86_regfile_2w2r_read_mux.sv
// One decode read port: zero for invalid IDs, optional write-through bypass, else stored value.
module rf_read_mux
    import y86_pkg::*;
#(
    parameter int         XLEN    = XLEN_DEF,
    parameter int         NREGS   = 15,
    parameter logic [3:0] NONE_ID = RNONE,
    parameter bit         BYPASS  = 1'b1
) (
    input  logic [3:0]      src,
    input  logic [XLEN-1:0] stored_val,
    input  logic            e_active,
    input  logic [3:0]      dst_e,
    input  logic [XLEN-1:0] val_e,
    input  logic            m_active,
    input  logic [3:0]      dst_m,
    input  logic [XLEN-1:0] val_m,
    output logic [XLEN-1:0] val
);

    // M-port data has priority over E-port data, matching the write collision rule
    always_comb begin
        val = '0;
        if (id_in_range(src, NONE_ID, NREGS)) begin
            if (BYPASS && m_active && (dst_m == src)) begin
                val = val_m;
            end else if (BYPASS && e_active && (dst_e == src)) begin
                val = val_e;
            end else begin
                val = stored_val;
            end
        end
    end

endmodule

// File: rtl/y86_regfile_2w2r.sv
// Y86-64 register file: two write ports (E, M), two bypassed read ports, debug read, write counter.
module y86_regfile_2w2r #(
    parameter int          XLEN     = y86_pkg::XLEN_DEF,
    parameter int          NREGS    = 15,
    parameter logic [3:0]  RNONE    = y86_pkg::RNONE,
    parameter int          RSP_IDX  = 4,
    parameter logic [63:0] RSP_INIT = 64'h0,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [3:0]      dstE,
    input  logic [XLEN-1:0] valE,
    input  logic [3:0]      dstM,
    input  logic [XLEN-1:0] valM,
    input  logic [3:0]      srcA,
    output logic [XLEN-1:0] valA,
    input  logic [3:0]      srcB,
    output logic [XLEN-1:0] valB,
    input  logic [3:0]      dbg_sel,
    output logic [XLEN-1:0] dbg_val,
    output logic [31:0]     wr_cnt
);
    import y86_pkg::*;

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [31:0]     wr_cnt_q;
    logic [31:0]     wr_cnt_d;
    logic [32:0]     cnt_sum;
    logic [1:0]      wr_num;
    logic            e_active;
    logic            m_active;
    logic [XLEN-1:0] stored_a;
    logic [XLEN-1:0] stored_b;

    // A port is active only outside reset, with writes enabled and a real destination
    always_comb begin
        e_active = wr_en && rst_n && id_in_range(dstE, RNONE, NREGS);
        m_active = wr_en && rst_n && id_in_range(dstM, RNONE, NREGS);
    end

    // Next array contents; the M port is applied last so it wins a collision
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NREGS; i++) begin
            if (e_active && (dstE == 4'(i))) regs_d[i] = valE;
            if (m_active && (dstM == 4'(i))) regs_d[i] = valM;
        end
    end

    // Distinct registers written this edge, saturating accumulation into the counter
    always_comb begin
        if (e_active && m_active && (dstE == dstM)) begin
            wr_num = 2'd1;
        end else begin
            wr_num = {1'b0, e_active} + {1'b0, m_active};
        end
        cnt_sum  = {1'b0, wr_cnt_q} + {31'b0, wr_num};
        wr_cnt_d = cnt_sum[32] ? 32'hFFFF_FFFF : cnt_sum[31:0];
    end

    // Array and counter state; reset loads the stack pointer with its initial value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= (i == RSP_IDX) ? XLEN'(RSP_INIT) : '0;
            end
            wr_cnt_q <= '0;
        end else begin
            regs_q   <= regs_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    // Stored-value lookups for both read ports and the debug port
    always_comb begin
        stored_a = '0;
        stored_b = '0;
        dbg_val  = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (srcA == 4'(i))    stored_a = regs_q[i];
            if (srcB == 4'(i))    stored_b = regs_q[i];
            if (dbg_sel == 4'(i)) dbg_val  = regs_q[i];
        end
        if (dbg_sel == RNONE) dbg_val = '0;
    end

    rf_read_mux #(
        .XLEN    (XLEN),
        .NREGS   (NREGS),
        .NONE_ID (RNONE),
        .BYPASS  (BYPASS)
    ) u_read_a (
        .src        (srcA),
        .stored_val (stored_a),
        .e_active   (e_active),
        .dst_e      (dstE),
        .val_e      (valE),
        .m_active   (m_active),
        .dst_m      (dstM),
        .val_m      (valM),
        .val        (valA)
    );

    rf_read_mux #(
        .XLEN    (XLEN),
        .NREGS   (NREGS),
        .NONE_ID (RNONE),
        .BYPASS  (BYPASS)
    ) u_read_b (
        .src        (srcB),
        .stored_val (stored_b),
        .e_active   (e_active),
        .dst_e      (dstE),
        .val_e      (valE),
        .m_active   (m_active),
        .dst_m      (dstM),
        .val_m      (valM),
        .val        (valB)
    );

    assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_y86_regfile_2w2r.sv
// Bench for y86_regfile_2w2r: bypassed 15-register build, non-bypassed build and 8-register build.
module tb_y86_regfile_2w2r;

    localparam logic [3:0] NONE = 4'hF;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [3:0]  dst_e;
    logic [63:0] val_e;
    logic [3:0]  dst_m;
    logic [63:0] val_m;
    logic [3:0]  src_a;
    logic [3:0]  src_b;
    logic [3:0]  dbg_sel;

    logic [63:0] va_1, vb_1, dv_1;
    logic [63:0] va_2, vb_2, dv_2;
    logic [63:0] va_3, vb_3, dv_3;
    logic [31:0] cnt_1, cnt_2, cnt_3;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        wr_en;
        logic [3:0]  dst_e;
        logic [63:0] val_e;
        logic [3:0]  dst_m;
        logic [63:0] val_m;
        logic [3:0]  src_a;
        logic [3:0]  src_b;
        logic [3:0]  dbg;
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] ed;
        logic [31:0] ec;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];
    vec_t exp_q [$];

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    y86_regfile_2w2r #(.NREGS(15), .RSP_INIT(64'h200), .BYPASS(1'b1)) dut_byp (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en),
        .dstE(dst_e), .valE(val_e), .dstM(dst_m), .valM(val_m),
        .srcA(src_a), .valA(va_1), .srcB(src_b), .valB(vb_1),
        .dbg_sel(dbg_sel), .dbg_val(dv_1), .wr_cnt(cnt_1)
    );

    y86_regfile_2w2r #(.NREGS(15), .RSP_INIT(64'h200), .BYPASS(1'b0)) dut_nobyp (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en),
        .dstE(dst_e), .valE(val_e), .dstM(dst_m), .valM(val_m),
        .srcA(src_a), .valA(va_2), .srcB(src_b), .valB(vb_2),
        .dbg_sel(dbg_sel), .dbg_val(dv_2), .wr_cnt(cnt_2)
    );

    y86_regfile_2w2r #(.NREGS(8), .RSP_INIT(64'h200), .BYPASS(1'b1)) dut_n8 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en),
        .dstE(dst_e), .valE(val_e), .dstM(dst_m), .valM(val_m),
        .srcA(src_a), .valA(va_3), .srcB(src_b), .valB(vb_3),
        .dbg_sel(dbg_sel), .dbg_val(dv_3), .wr_cnt(cnt_3)
    );

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one vector just after a falling edge and queue its expected outputs
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        wr_en   = v.wr_en;
        dst_e   = v.dst_e;
        val_e   = v.val_e;
        dst_m   = v.dst_m;
        val_m   = v.val_m;
        src_a   = v.src_a;
        src_b   = v.src_b;
        dbg_sel = v.dbg;
        exp_q.push_back(v);
    endtask

    // Let the combinational paths settle, then compare against the oldest queued entry
    task automatic checkOutput(input int idx);
        vec_t e;
        #2;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL vec%0d scoreboard: got empty queue, expected an entry", idx);
        end else begin
            e = exp_q.pop_front();
            checkVal($sformatf("vec%0d valA", idx), va_1, e.ea);
            checkVal($sformatf("vec%0d valB", idx), vb_1, e.eb);
            checkVal($sformatf("vec%0d dbg_val", idx), dv_1, e.ed);
            checkVal($sformatf("vec%0d wr_cnt", idx), {32'b0, cnt_1}, {32'b0, e.ec});
        end
    endtask

    initial begin
        // wr_en dstE valE dstM valM srcA srcB dbg | valA valB dbg_val wr_cnt (state before the edge)
        vecs[0] = '{1'b0, NONE, 64'h0,     NONE, 64'h0,  4'd4, 4'd0, 4'd4, 64'h200,  64'h0,    64'h200,  32'd0};
        vecs[1] = '{1'b1, 4'd3, 64'hDEAD,  NONE, 64'h0,  4'd3, 4'd1, 4'd3, 64'hDEAD, 64'h0,    64'h0,    32'd0};
        vecs[2] = '{1'b0, 4'd3, 64'h1,     NONE, 64'h0,  4'd3, 4'd3, 4'd3, 64'hDEAD, 64'hDEAD, 64'hDEAD, 32'd1};
        vecs[3] = '{1'b1, 4'd4, 64'h1F8,   4'd4, 64'h55, 4'd4, 4'd3, 4'd4, 64'h55,   64'hDEAD, 64'h200,  32'd1};
        vecs[4] = '{1'b1, 4'd4, 64'h1F0,   4'd0, 64'h7,  4'd4, 4'd0, 4'd4, 64'h1F0,  64'h7,    64'h55,   32'd2};
        vecs[5] = '{1'b0, NONE, 64'h0,     NONE, 64'h0,  4'd4, 4'd0, 4'd0, 64'h1F0,  64'h7,    64'h7,    32'd4};
        vecs[6] = '{1'b1, NONE, 64'hFF,    NONE, 64'h1,  NONE, NONE, NONE, 64'h0,    64'h0,    64'h0,    32'd4};
        vecs[7] = '{1'b1, 4'd5, 64'hAA,    4'd5, 64'hBB, 4'd5, 4'd5, 4'd5, 64'hBB,   64'hBB,   64'h0,    32'd4};
        vecs[8] = '{1'b1, 4'd14, 64'h1414, NONE, 64'h0,  4'd5, 4'd14, 4'd5, 64'hBB,  64'h1414, 64'hBB,   32'd5};
        vecs[9] = '{1'b0, NONE, 64'h0,     NONE, 64'h0,  4'd14, 4'd4, 4'd14, 64'h1414, 64'h1F0, 64'h1414, 32'd6};

        rst_n   = 1'b0;
        wr_en   = 1'b0;
        dst_e   = NONE;
        val_e   = '0;
        dst_m   = NONE;
        val_m   = '0;
        src_a   = NONE;
        src_b   = NONE;
        dbg_sel = NONE;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] reset released, applying vector table");

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i);
        end

        // Reset asserted mid-cycle with a write pending: contents change immediately, no bypass
        @(negedge clk);
        wr_en = 1'b1; dst_e = 4'd3; val_e = 64'h77; dst_m = NONE;
        src_a = 4'd3; src_b = 4'd4; dbg_sel = 4'd14;
        #3;
        rst_n = 1'b0;
        #1;
        checkVal("async reset valA", va_1, 64'h0);
        checkVal("async reset valB rsp", vb_1, 64'h200);
        checkVal("async reset dbg_val", dv_1, 64'h0);
        checkVal("async reset wr_cnt", {32'b0, cnt_1}, 64'h0);
        @(negedge clk);
        wr_en = 1'b0;
        rst_n = 1'b1;
        #2;
        checkVal("after reset reg3", va_1, 64'h0);

        // Bypass versus stored-value read of a register being rewritten
        @(negedge clk);
        wr_en = 1'b1; dst_e = 4'd2; val_e = 64'hA; dst_m = NONE;
        src_a = NONE; src_b = NONE; dbg_sel = NONE;
        @(negedge clk);
        dst_e = 4'd2; val_e = 64'hB; src_b = 4'd2; dbg_sel = 4'd2;
        #2;
        checkVal("bypass on valB", vb_1, 64'hB);
        checkVal("bypass off valB", vb_2, 64'hA);
        checkVal("bypass on dbg_val", dv_1, 64'hA);
        checkVal("bypass off dbg_val", dv_2, 64'hA);
        @(negedge clk);
        wr_en = 1'b0;
        #2;
        checkVal("bypass on valB after edge", vb_1, 64'hB);
        checkVal("bypass off valB after edge", vb_2, 64'hB);
        checkVal("bypass off wr_cnt", {32'b0, cnt_2}, 64'd2);

        // Out-of-range destination on the 8-register build is silently dropped
        @(negedge clk);
        wr_en = 1'b1; dst_e = 4'd9; val_e = 64'hFF; dst_m = NONE;
        src_a = 4'd9; src_b = 4'd2; dbg_sel = 4'd9;
        #2;
        checkVal("n8 valA id9 same cycle", va_3, 64'h0);
        checkVal("n15 valA id9 bypass", va_1, 64'hFF);
        checkVal("n8 wr_cnt before edge", {32'b0, cnt_3}, 64'd2);
        @(negedge clk);
        wr_en = 1'b0;
        #2;
        checkVal("n8 valA id9 stored", va_3, 64'h0);
        checkVal("n8 dbg_val id9", dv_3, 64'h0);
        checkVal("n8 wr_cnt unchanged", {32'b0, cnt_3}, 64'd2);
        checkVal("n8 valB reg2", vb_3, 64'hB);
        checkVal("n15 valA id9 stored", va_1, 64'hFF);
        checkVal("n15 wr_cnt", {32'b0, cnt_1}, 64'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
